// File: rtl/attention_ctrl.sv
// ---------------------------------------------------------------------------
// attention_ctrl
//   Top-level sequencer for the attention datapath. Loads one input sequence
//   (SEQ_LEN*D_MODEL words) into the token buffer, then walks the stacked
//   attention blocks in order. Each block is stepped through the PROJ, SCORE,
//   SOFTMAX and WSUM phases with a phase_start / phase_done handshake.
//
// Ports
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start             begin a run (sampled in IDLE only)
//   num_blocks        blocks to run, sampled with start; 0 runs one block,
//                     values above 2**BLK_W run 2**BLK_W blocks
//   data_in(_valid)   input word stream, consumed only while in_ready=1
//   in_ready          controller is loading the token buffer
//   buf_wr_*          registered token buffer write port
//   block_sel, phase  current block index and phase (0 PROJ .. 3 WSUM)
//   phase_start       one-cycle pulse launching the current phase
//   phase_done        datapath finished the current phase
//   busy              run in progress
//   done              one-cycle pulse at run end
//   err               sticky watchdog error
//
// Optional build macro
//   ATTN_CTRL_TIMEOUT_EN  adds a TO_W-bit watchdog on every phase wait. When
//                         it expires, err is set (sticky until rst) and the
//                         run ends with a done pulse. Without the macro err
//                         is tied 0 and a phase wait never times out.
// ---------------------------------------------------------------------------
module attention_ctrl #(
  parameter int DATA_W  = 16,
  parameter int SEQ_LEN = 5,
  parameter int D_MODEL = 6,
  parameter int BLK_W   = 3,
  parameter int ADDR_W  = 5,
  parameter int TO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BLK_W:0]    num_blocks,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              in_ready,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic [BLK_W-1:0]  block_sel,
  output logic [1:0]        phase,
  output logic              phase_start,
  input  logic              phase_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TOTAL = SEQ_LEN * D_MODEL;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [1:0] PH_PROJ = 2'd0;
  localparam logic [1:0] PH_WSUM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN_START,
    S_RUN_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] wcnt;
  logic [BLK_W-1:0]  nb_last;   // index of the final block of this run
  logic [BLK_W-1:0]  blk;
  logic [1:0]        ph;
  logic              accept;
  logic              last_word;
  logic              timeout;

  logic              wr_en_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;

  // Clamp the requested block count to 1..2**BLK_W and return the index of
  // the last block, which is what the NEXT state compares against.
  function automatic logic [BLK_W-1:0] last_blk_idx(input logic [BLK_W:0] n);
    logic [BLK_W:0] m;
    m = n;
    if (m == '0)
      m = {{BLK_W{1'b0}}, 1'b1};
    else if (m > {1'b1, {BLK_W{1'b0}}})
      m = {1'b1, {BLK_W{1'b0}}};
    m = m - 1'b1;
    return m[BLK_W-1:0];
  endfunction

  assign accept    = (state == S_LOAD) && data_in_valid;
  assign last_word = accept && (wcnt == LAST_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_LOAD;
      S_LOAD:      if (last_word) state_nxt = S_RUN_START;
      S_RUN_START: state_nxt = S_RUN_WAIT;
      S_RUN_WAIT: begin
        if (phase_done)
          state_nxt = (ph == PH_WSUM) ? S_NEXT : S_RUN_START;
        else if (timeout)
          state_nxt = S_FIN;
      end
      S_NEXT:      state_nxt = (blk == nb_last) ? S_FIN : S_RUN_START;
      S_FIN:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      nb_last <= '0;
      blk     <= '0;
      ph      <= PH_PROJ;
    end else begin
      state <= state_nxt;
      if (accept)
        wcnt <= wcnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            nb_last <= last_blk_idx(num_blocks);
            wcnt    <= '0;
            blk     <= '0;
            ph      <= PH_PROJ;
          end
        end
        S_LOAD: begin
          if (last_word) begin
            blk <= '0;
            ph  <= PH_PROJ;
          end
        end
        S_RUN_WAIT: begin
          if (phase_done && (ph != PH_WSUM))
            ph <= ph + 1'b1;
        end
        S_NEXT: begin
          if (blk != nb_last) begin
            blk <= blk + 1'b1;
            ph  <= PH_PROJ;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered token buffer write, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= accept;
      if (accept) begin
        wr_addr_p1 <= wcnt;
        wr_data_p1 <= data_in;
      end
    end
  end

`ifdef ATTN_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // Fires on the wait cycle in which the counter would reach all-ones.
  assign timeout = (state == S_RUN_WAIT) && !phase_done &&
                   (TO_W'(to_cnt + 1'b1) == {TO_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_RUN_START)
        to_cnt <= '0;
      else if (state == S_RUN_WAIT)
        to_cnt <= to_cnt + 1'b1;
      if (timeout)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_to;
  assign unused_to = ^TO_W;
  assign timeout   = 1'b0;
  assign err       = 1'b0;
`endif

  assign in_ready    = (state == S_LOAD);
  assign phase_start = (state == S_RUN_START);
  assign done        = (state == S_FIN);
  assign busy        = (state != S_IDLE);
  assign block_sel   = blk;
  assign phase       = ph;
  assign buf_wr_en   = wr_en_p1;
  assign buf_wr_addr = wr_addr_p1;
  assign buf_wr_data = wr_data_p1;

endmodule

// File: doc/attention_ctrl.md
Name: attention_ctrl

Overview:
Top-level sequencer for the attention datapath. Ingests one input sequence of SEQ_LEN*D_MODEL 16-bit words into the token buffer. It then runs the stacked attention blocks in order, selecting each one via block_sel. For each block it steps the datapath through the PROJ, SCORE, SOFTMAX and WSUM phases using a start/done handshake. It sits between the stream source and the attention datapath.

Parameters:
DATA_W, 16, input word width
SEQ_LEN, 5, tokens per sequence
D_MODEL, 6, words per token
BLK_W, 3, block_sel width; max blocks = 2**BLK_W
ADDR_W, 5, buffer address width; must satisfy 2**ADDR_W >= SEQ_LEN*D_MODEL
TO_W, 16, watchdog counter width (optional feature only)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a run; sampled in IDLE only
num_blocks  in  BLK_W+1  blocks to run; sampled with start
data_in  in  DATA_W  input stream word
data_in_valid  in  1  data_in qualifier
in_ready  out  1  controller accepts words (LOAD only)
buf_wr_en  out  1  token buffer write strobe
buf_wr_addr  out  ADDR_W  token buffer write address
buf_wr_data  out  DATA_W  token buffer write data
block_sel  out  BLK_W  current block index
phase  out  2  0=PROJ 1=SCORE 2=SOFTMAX 3=WSUM
phase_start  out  1  one-cycle pulse starting a phase
phase_done  in  1  datapath finished the current phase
busy  out  1  high from start acceptance to done
done  out  1  one-cycle pulse at run end
err  out  1  sticky watchdog error (optional feature; tied 0 otherwise)

Behaviour:
- Reset: state=IDLE. All outputs are 0: in_ready, buf_wr_en, buf_wr_addr, buf_wr_data, block_sel, phase, phase_start, busy, done, err. Reset mid-run aborts immediately, with no done pulse.
- States: IDLE, LOAD, RUN_START, RUN_WAIT, NEXT, FIN.
- IDLE: on start=1, latch nb = clamp(num_blocks, 1, 2**BLK_W). A value of 0 runs 1 block. Set busy=1, word count=0, go to LOAD.
- LOAD: in_ready=1.
  - Each cycle with data_in_valid=1 writes one word.
  - buf_wr_en/addr/data are registered, so the write appears 1 cycle after acceptance.
  - Addresses run 0..SEQ_LEN*D_MODEL-1.
  - On the last word accepted: in_ready drops the next cycle, block_sel=0, phase=PROJ, go to RUN_START.
  - Gaps in data_in_valid stall the count; nothing is lost.
- RUN_START: phase_start=1 for exactly one cycle, then go to RUN_WAIT.
- RUN_WAIT: wait for phase_done=1.
  - If phase<3: phase+1 and go to RUN_START.
  - If phase=3: go to NEXT.
  - phase_done is ignored in every other state, including the RUN_START cycle.
- NEXT:
  - If block_sel==nb-1, go to FIN.
  - Otherwise block_sel+1, phase=PROJ, go to RUN_START.
  - One cycle.
- FIN: done=1 for one cycle; busy=0 from the following cycle; return to IDLE.
  - block_sel and phase hold their final values until the next start.
- Outside LOAD, in_ready=0 and data_in/data_in_valid are ignored.
- start while busy is ignored. start and the done pulse in the same cycle are also ignored, because FIN is not IDLE.
- Minimum latency, from last word accepted to done with phase_done returned immediately: nb*4*2 + nb + 2 cycles.

Optional Feature:
Macro ATTN_CTRL_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entering RUN_WAIT and increments every RUN_WAIT cycle.
  - If it reaches all-ones without phase_done: err=1 (sticky until rst), done pulses one cycle, return to IDLE (busy=0).
  - The next start clears nothing except busy flow; err persists until rst.
- Undefined: no counter; err tied 0; RUN_WAIT waits forever.

Test Plan:
1. rst=1 for 3 cycles, then start with num_blocks=1. Feed 30 back-to-back words 0x0000..0x001D. Expected:
   - buf_wr_addr 0..29 with matching data, each 1 cycle after acceptance.
   - in_ready=0 after the 30th word.
   - phase_start pulses with phase 0,1,2,3 (bench returns phase_done 2 cycles after each start).
   - Then done pulses once, with block_sel=0 throughout.
2. num_blocks=3 with immediate phase_done. Expected: 12 phase_start pulses; block_sel steps 0→1→2 after each WSUM; done once; busy low the cycle after done.
3. data_in_valid toggling 1,0,1,0 during LOAD, plus 5 extra valid words after LOAD. Expected: exactly 30 writes, no write for the extra words, addresses contiguous.
4. Boundary cases:
   - num_blocks=0 runs 1 block.
   - num_blocks=15 runs 8 blocks (block_sel ends at 7).
   - phase_done asserted during LOAD and IDLE causes no state change.
5. Reset mid-operation: rst asserted during RUN_WAIT of block 1, phase SOFTMAX. Expected: the next cycle all outputs are 0 and state is IDLE; a new start runs a full load correctly.
6. With ATTN_CTRL_TIMEOUT_EN and TO_W=4: withhold phase_done. Expected: after 15 RUN_WAIT cycles err=1 and done pulses once; err stays 1 through the next run until rst.
